// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed seven-segment display path.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned DISP_W     = 16;

    // Extract the BCD nibble shown at position sel (position 0 is the rightmost digit).
    function automatic logic [DIGIT_W-1:0] nibble_sel(input logic [DISP_W-1:0] data,
                                                      input logic [SEL_W-1:0]  sel);
        return data[sel*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler: counts 0..DIV-1 and flags the terminal count.
module tick_divider #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    // Next count: wrap to zero on the terminal count.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed display with frame-synchronous,
// double-buffered updates, leading-zero blanking and whole-display blink.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic               src_clk,
    input  logic               src_rst_n,
    input  logic               upd_valid,
    input  logic [DISP_W-1:0]  upd_data,
    output logic               upd_ready,
    input  logic               lz_blank_en,
    input  logic               blink_en,
    output logic [SEL_W-1:0]   select,
    output logic [DIGIT_W-1:0] digit_val,
    output logic               digit_blank,
    output logic               frame_tick
);

    localparam int unsigned BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic dwell_end;
    logic frame_end;
    logic accept;

    logic [SEL_W-1:0]   select_q, select_d;
    logic [DIGIT_W-1:0] val_q, val_d;
    logic               blank_q, blank_d;
    logic               frame_tick_q;
    logic [DISP_W-1:0]  disp_q, disp_d;
    logic [DISP_W-1:0]  pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic               bphase_q, bphase_d;

    tick_divider #(
        .DIV (REFRESH_DIV)
    ) u_tick_divider (
        .clk   (src_clk),
        .rst_n (src_rst_n),
        .tick  (dwell_end)
    );

    assign frame_end = dwell_end & (select_q == SEL_W'(NUM_DIGITS - 1));
    assign accept    = upd_valid & ~pend_full_q;

    assign upd_ready   = ~pend_full_q;
    assign select      = select_q;
    assign digit_val   = val_q;
    assign digit_blank = blank_q;
    assign frame_tick  = frame_tick_q;

    // True when position sel and every more-significant position hold zero.
    // Position 0 always stays lit.
    function automatic logic leading_zero(input logic [DISP_W-1:0] data,
                                          input logic [SEL_W-1:0]  sel);
        logic lz;
        lz = (sel != '0);
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (k >= int'(sel) && nibble_sel(data, SEL_W'(k)) != '0) begin
                lz = 1'b0;
            end
        end
        return lz;
    endfunction

    // Buffer handoff, blink sequencing and next displayed digit.
    always_comb begin
        select_d    = select_q;
        val_d       = val_q;
        blank_d     = blank_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        bcnt_d      = bcnt_q;
        bphase_d    = bphase_q;

        // Commit and accept are mutually exclusive since ready is low while full.
        if (frame_end && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = upd_data;
            pend_full_d = 1'b1;
        end

        if (dwell_end) begin
            select_d = select_q + SEL_W'(1);

            if (!blink_en) begin
                bcnt_d   = '0;
                bphase_d = 1'b0;
            end else if (frame_end) begin
                if (bcnt_q == BCNT_W'(BLINK_FRAMES - 1)) begin
                    bcnt_d   = '0;
                    bphase_d = ~bphase_q;
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end

            // Use the post-commit value so a new frame shows new data from select 0.
            val_d   = nibble_sel(disp_d, select_d);
            blank_d = (blink_en & bphase_d) | (lz_blank_en & leading_zero(disp_d, select_d));
        end
    end

    // State and registered outputs.
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            select_q     <= '0;
            val_q        <= '0;
            blank_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            bcnt_q       <= '0;
            bphase_q     <= 1'b0;
        end else begin
            select_q     <= select_d;
            val_q        <= val_d;
            blank_q      <= blank_d;
            frame_tick_q <= frame_end;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            bcnt_q       <= bcnt_d;
            bphase_q     <= bphase_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl against a cycle-count based reference model.
module tb_display_scan_ctrl;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BF    = 2;
    localparam int unsigned FRAME = 4 * DIV;

    logic        src_clk;
    logic        src_rst_n;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic        upd_ready;
    logic        lz_blank_en;
    logic        blink_en;
    logic [1:0]  select;
    logic [3:0]  digit_val;
    logic        digit_blank;
    logic        frame_tick;

    int vectors;
    int miscompares;

    // Reference model state.
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_full;
    int          m_sel;
    logic [3:0]  m_val;
    logic        m_blank;
    logic        m_tick;
    int          m_en_frames;

    display_scan_ctrl #(
        .REFRESH_DIV  (DIV),
        .BLINK_FRAMES (BF)
    ) dut (
        .src_clk     (src_clk),
        .src_rst_n   (src_rst_n),
        .upd_valid   (upd_valid),
        .upd_data    (upd_data),
        .upd_ready   (upd_ready),
        .lz_blank_en (lz_blank_en),
        .blink_en    (blink_en),
        .select      (select),
        .digit_val   (digit_val),
        .digit_blank (digit_blank),
        .frame_tick  (frame_tick)
    );

    initial src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_disp = '0; m_pend = '0; m_full = 1'b0;
        m_sel = 0; m_val = '0; m_blank = 1'b0; m_tick = 1'b0; m_en_frames = 0;
    endtask

    // One rising edge of the model; t counts edges since reset release.
    task automatic model_edge(input logic v, input logic [15:0] d);
        bit dwell, frame;
        m_t++;
        dwell = (m_t % DIV) == 0;
        frame = (m_t % FRAME) == 0;
        if (frame && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
        end else if (v && !m_full) begin
            m_pend = d;
            m_full = 1'b1;
        end
        m_tick = frame;
        if (dwell) begin
            if (!blink_en) m_en_frames = 0;
            else if (frame) m_en_frames++;
            m_sel   = (m_t / DIV) % 4;
            m_val   = 4'((m_disp >> (4 * m_sel)) & 16'hF);
            m_blank = (blink_en && ((m_en_frames / BF) % 2 == 1)) ||
                      (lz_blank_en && m_sel != 0 && (m_disp >> (4 * m_sel)) == 0);
        end
    endtask

    task automatic check_outputs();
        check("select", 16'(select), 16'(m_sel));
        check("digit_val", 16'(digit_val), 16'(m_val));
        check("digit_blank", 16'(digit_blank), 16'(m_blank));
        check("frame_tick", 16'(frame_tick), 16'(m_tick));
        check("upd_ready", 16'(upd_ready), 16'(!m_full));
    endtask

    task automatic check_reset_values();
        check("rst_select", 16'(select), 16'h0);
        check("rst_digit_val", 16'(digit_val), 16'h0);
        check("rst_digit_blank", 16'(digit_blank), 16'h0);
        check("rst_frame_tick", 16'(frame_tick), 16'h0);
        check("rst_upd_ready", 16'(upd_ready), 16'h1);
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        upd_valid = v;
        upd_data  = d;
        @(posedge src_clk);
        model_edge(v, d);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, upd_data);
    endtask

    // Offer d until it is taken, with a bounded wait.
    task automatic write(input logic [15:0] d);
        bit taken;
        taken = 1'b0;
        for (int i = 0; i < 4 * FRAME && !taken; i++) begin
            taken = !m_full;
            step(1'b1, d);
        end
        upd_valid = 1'b0;
        if (!taken) begin
            vectors++;
            miscompares++;
            $error("FAIL write_timeout: observed not accepted expected accepted data %0h", d);
        end
    endtask

    task automatic release_reset();
        @(negedge src_clk);
        src_rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [15:0] d;
        bit          hit;
        vectors = 0; miscompares = 0;
        upd_valid = 1'b0; upd_data = '0; lz_blank_en = 1'b0; blink_en = 1'b0;
        src_rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge src_clk);
        #1;
        check_reset_values();
        release_reset();

        // Free scan, then a write landing at cycle 2.
        step(1'b0, '0);
        write(16'h1234);
        idle(40);

        // Backpressure: second write waits for the first to commit.
        write(16'h1234);
        write(16'h5678);
        idle(2 * FRAME + 4);

        // Leading-zero blanking.
        lz_blank_en = 1'b1;
        write(16'h0050);
        idle(2 * FRAME);
        write(16'h0000);
        idle(2 * FRAME);
        write(16'h9A0F);
        idle(2 * FRAME);

        // Blink: run several blink periods, then drop it while dark.
        blink_en = 1'b1;
        idle(8 * FRAME);
        hit = 1'b0;
        for (int i = 0; i < 8 * FRAME && !hit; i++) begin
            step(1'b0, upd_data);
            hit = m_blank && blink_en && (m_en_frames / BF) % 2 == 1;
        end
        check("blink_dark_reached", 16'(hit), 16'h1);
        blink_en = 1'b0;
        idle(2 * FRAME);

        // Randomised traffic and enable toggles.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 39) == 0) lz_blank_en = ~lz_blank_en;
            if ($urandom_range(0, 59) == 0) blink_en = ~blink_en;
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) d = d >> (4 * $urandom_range(1, 4));
            step($urandom_range(0, 3) == 0, d);
        end
        blink_en = 1'b0;

        // Reset mid-frame with pending data at select 2.
        hit = 1'b0;
        for (int i = 0; i < 8 * FRAME && !hit; i++) begin
            step(!m_full, 16'hBEEF);
            hit = m_full && m_sel == 2 && m_pend == 16'hBEEF;
        end
        upd_valid = 1'b0;
        check("midreset_setup", 16'(hit), 16'h1);
        #2;
        src_rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge src_clk);
        #1;
        check_reset_values();
        release_reset();
        idle(3 * FRAME);
        check("pending_discarded", 16'(m_disp), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Scan controller for the 4-digit multiplexed seven-segment display. It steps the digit select through positions 0..3 at a programmable dwell rate, and presents the matching BCD nibble and a blank flag to the per-digit decoder/driver. Game logic writes new scores through a ready/valid port. Updates are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits. Optional leading-zero blanking and whole-display blink are applied per digit.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit is shown (dwell). Legal range ≥2.
- BLINK_FRAMES, 64: frames per blink half-period. Legal range ≥1.
- src_clk  in  1  system clock; all logic is on its rising edge.
- src_rst_n  in  1  asynchronous, active-low reset.
- upd_valid  in  1  new display value offered.
- upd_data  in  16  four BCD nibbles; [3:0] is digit 0 (rightmost, select 0), [15:12] is digit 3.
- upd_ready  out  1  pending buffer empty; transfer occurs when upd_valid & upd_ready.
- lz_blank_en  in  1  enable leading-zero blanking.
- blink_en  in  1  enable whole-display blink.
- select  out  2  active digit position, to the decoder select input.
- digit_val  out  4  nibble for the active position.
- digit_blank  out  1  1 = active position must be dark (decoder drives anodes off).
- frame_tick  out  1  one-cycle pulse per completed 4-digit frame.

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps. Its terminal count is dwell_end.
- On dwell_end, select increments mod 4. frame_end = dwell_end & (select==3).
- Buffers: disp_reg (committed, 16b), pend_reg (16b), pend_full. upd_ready = ~pend_full.
- Accept: pend_reg <= upd_data, pend_full <= 1.
- On frame_end with pend_full=1: disp_reg <= pend_reg, pend_full <= 0.
- Accept and frame_end in the same cycle with pend_full=0: the data goes to pend_reg. It commits at the following frame_end; there is no bypass.
- Accept can never coincide with a commit, because ready is 0 while pend_full=1.
- digit_val, digit_blank and select are registered and update together on the dwell_end edge. They are computed from the next select and the next disp_reg, so a commit is visible at select 0 on the same edge.
- Nibbles greater than 9 pass through unchanged.
- Leading-zero blanking: position k (k=1..3) is blanked when lz_blank_en=1 and every nibble from 3 down to k is 0. Position 0 is never LZ-blanked.
- Blink: a frame counter runs 0..BLINK_FRAMES-1. On wrap at frame_end, blink_phase toggles.
  - When blink_en=1 and blink_phase=1, all positions are blanked.
  - When blink_en=0, the counter and blink_phase are held at 0.
- lz_blank_en and blink_en are sampled only at dwell_end edges.
- frame_tick is registered and asserts the cycle after frame_end.

## Timing
- Reset values: select=0, digit_val=0, digit_blank=0, upd_ready=1, frame_tick=0. Prescaler, frame counter, blink_phase, disp_reg and pend_reg all clear to 0.
- First dwell_end occurs REFRESH_DIV cycles after reset deassertion. Each position holds for exactly REFRESH_DIV cycles; a frame is 4*REFRESH_DIV cycles.
- upd_ready falls the cycle after acceptance. It rises the cycle after the commit edge.
- Accept-to-display latency is 1..4*REFRESH_DIV cycles (to the next frame_end), plus 4*REFRESH_DIV if the accept coincides with frame_end.
- Enable-input changes take effect at the next digit boundary.
- Reset mid-operation: all state clears immediately. Pending data is discarded and the display restarts at select 0.

## Structure
- Shared package display_pkg holds:
  - NUM_DIGITS=4, DIGIT_W=4, SEL_W=2, DISP_W=16;
  - the nibble-select function, reused by other display code.
- One sub-module, tick_divider: a parameterised prescaler producing the dwell_end pulse, with the same clock/reset convention.
- All buffering, blanking and blink logic lives in the top module.

## Test plan
Bench parameters: REFRESH_DIV=4, BLINK_FRAMES=2.
- Reset/scan: hold src_rst_n low → all outputs at reset values, upd_ready=1. Release → select runs 0,1,2,3,0 every 4 cycles; frame_tick pulses every 16 cycles, first on cycle 16.
- Update: write 0x1234 at cycle 2 → upd_ready=0 from cycle 3. At the first frame_end, digit_val is 4,3,2,1 for select 0..3, and upd_ready returns the next cycle. The old value 0x0000 is shown for the whole prior frame.
- Backpressure: write 0x1234, then hold upd_valid with 0x5678 → not accepted until upd_ready=1. The next frame shows 0x1234, the frame after shows 0x5678; no data lost or duplicated.
- LZ blanking: commit 0x0050 with lz_blank_en=1 → select 3 and 2 blank, select 1 shows 5, select 0 shows 0 unblanked. Commit 0x0000 → only select 0 visible.
- Blink: blink_en=1 → frames 0-1 visible, frames 2-3 fully blanked, repeating. Drop blink_en during a blanked frame → visible from the next digit boundary.
- Reset mid-frame: pend_full=1, select=2, assert src_rst_n → outputs clear asynchronously, upd_ready=1. The pending value never appears.
